// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one pipelined FP adder between N_REQ requesters.
// Define FP_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module fp_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W = 2,
    parameter int ADD_LATENCY = 1,
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W-1:0]        req_a,
    input  logic [N_REQ*W-1:0]        req_b,
    output logic [W-1:0]              add_a,
    output logic [W-1:0]              add_b,
    input  logic                      add_sign,
    input  logic [EXPONENT_WIDTH-1:0] add_exp,
    input  logic [MANTISSA_WIDTH-1:0] add_mant,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [W-1:0]              res_data,
    output logic                      idle
);
    logic [N_REQ-1:0] pending, eligible, clr;
    logic [ADD_LATENCY:0] tag_v;
    logic [ID_W-1:0] tag_id [ADD_LATENCY+1];
    logic grant;
    logic [ID_W-1:0] gid;
`ifndef FP_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr;
    logic [N_REQ-1:0] rot;
`endif

    assign eligible = req_valid & ~pending;
`ifdef FP_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 1'b0;
        gid = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant = 1'b1;
                gid = ID_W'(k);
            end
        end
    end
`else
    // rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins
    assign rot = N_REQ'({eligible, eligible} >> rr_ptr);
    always_comb begin
        grant = 1'b0;
        gid = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant = 1'b1;
                gid = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end
`endif

    assign req_ready = grant ? N_REQ'(1) << gid : '0;
    assign res_valid = tag_v[ADD_LATENCY];
    assign res_id = tag_id[ADD_LATENCY];
    assign res_data = {add_sign, add_exp, add_mant};
    assign clr = res_valid ? N_REQ'(1) << res_id : '0;
    assign idle = ~|tag_v & ~grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            add_a <= '0;
            add_b <= '0;
            pending <= '0;
            tag_v <= '0;
            for (int k = 0; k <= ADD_LATENCY; k++) tag_id[k] <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            if (grant) begin
                add_a <= req_a[int'(gid)*W +: W];
                add_b <= req_b[int'(gid)*W +: W];
`ifndef FP_ARB_FIXED_PRIO_EN
                rr_ptr <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
`endif
            end
            pending <= (pending & ~clr) | req_ready;
            tag_v <= {tag_v[ADD_LATENCY-1:0], grant};
            tag_id[0] <= gid;
            for (int k = 1; k <= ADD_LATENCY; k++) tag_id[k] <= tag_id[k-1];
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: scoreboard bench for fp_add_arbiter with a table-driven pipelined adder stub.
module tb_fp_add_arbiter;
    localparam int LAT = 3;
    localparam int P = LAT + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    logic [127:0] req_a = '0, req_b = '0;
    logic [31:0] add_a, add_b, res_data;
    logic add_sign;
    logic [7:0] add_exp;
    logic [22:0] add_mant;
    logic res_valid, idle;
    logic [1:0] res_id;

    int checks = 0, errors = 0, cyc = 0;
    logic [33:0] sb [$];
    logic [33:0] e;
    logic [31:0] apipe [LAT];

    fp_add_arbiter #(.N_REQ(4), .ID_W(2), .ADD_LATENCY(LAT), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b),
        .add_sign(add_sign), .add_exp(add_exp), .add_mant(add_mant),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40800000_BF800000: return 32'h40400000;
            64'h40C00000_40E00000: return 32'h41500000;
            64'h40E80000_3EC00000: return 32'h40F40000;
            64'hBF000000_3F000000: return 32'h00000000;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    always @(posedge clk) begin
        apipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign {add_sign, add_exp, add_mant} = apipe[LAT-1];

    always @(negedge clk) begin
        if (reset) sb.delete();
        else begin
            if (res_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected id=%0d data=%h", res_id, res_data);
                end else begin
                    e = sb.pop_front();
                    if ({res_id, res_data} !== e) begin
                        errors++;
                        $display("FAIL sb_result got id=%0d data=%h exp id=%0d data=%h", res_id, res_data, e[33:32], e[31:0]);
                    end
                end
            end
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && req_ready[i]) sb.push_back({2'(i), fadd(req_a[i*32 +: 32], req_b[i*32 +: 32])});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 60; n++) begin
            if (idle && sb.size() == 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout idle=%b queued=%0d", idle, sb.size());
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        tick();
        tick();
        checks++;
        if ({add_a, add_b} !== 64'h0) begin errors++; $display("FAIL reset_operands got=%h exp=0", {add_a, add_b}); end
        checks++;
        if ({res_valid, res_id} !== 3'b000) begin errors++; $display("FAIL reset_result got=%b exp=000", {res_valid, res_id}); end
        checks++;
        if ({idle, req_ready} !== 5'b10000) begin errors++; $display("FAIL reset_idle got=%b exp=10000", {idle, req_ready}); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int c, n;
        do_reset();
        set_ops(0, 32'h40800000, 32'hBF800000);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        c = cyc;
        tick();
        req_valid = '0;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        checks++;
        if (cyc - c !== 1 + LAT) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", cyc - c, 1 + LAT); end
        checks++;
        if ({res_valid, res_id, res_data} !== {1'b1, 2'd0, 32'h40400000}) begin
            errors++; $display("FAIL single_result got=%b/%0d/%h exp=1/0/40400000", res_valid, res_id, res_data);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", idle); end
    endtask

    task automatic test_all4();
        logic [31:0] exp_d [4];
        int j;
        exp_d = '{32'h41500000, 32'h40F40000, 32'h00000000, 32'h40400000};
        do_reset();
        set_ops(0, 32'h40C00000, 32'h40E00000);
        set_ops(1, 32'h40E80000, 32'h3EC00000);
        set_ops(2, 32'hBF000000, 32'h3F000000);
        set_ops(3, 32'h40800000, 32'hBF800000);
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << i)) begin errors++; $display("FAIL all4_grant%0d got=%b exp=%b", i, req_ready, 4'(1 << i)); end
            tick();
            req_valid[i] = 1'b0;
        end
        j = 0;
        for (int n = 0; n < 20 && j < 4; n++) begin
            if (res_valid) begin
                checks++;
                if ({res_id, res_data} !== {2'(j), exp_d[j]}) begin
                    errors++; $display("FAIL all4_result%0d got=%0d/%h exp=%0d/%h", j, res_id, res_data, j, exp_d[j]);
                end
                j++;
            end
            tick();
        end
        checks++;
        if (j !== 4) begin errors++; $display("FAIL all4_count got=%0d exp=4", j); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ops(1, 32'h40800000, 32'hBF800000);
        req_valid = 4'b0010;
        for (int t = 0; t <= 2 * P; t++) begin
            #1;
            checks++;
            if (req_ready !== ((t % P == 0) ? 4'b0010 : 4'b0000)) begin
                errors++; $display("FAIL b2b_ready t=%0d got=%b exp=%b", t, req_ready, (t % P == 0) ? 4'b0010 : 4'b0000);
            end
            tick();
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_fairness();
        logic [3:0] x;
        do_reset();
        set_ops(0, 32'h40800000, 32'hBF800000);
        set_ops(2, 32'h40800000, 32'hBF800000);
        req_valid = 4'b0101;
        for (int t = 0; t < 3 * P; t++) begin
            #1;
            x = (t % P == 0) ? 4'b0001 : (t % P == 1) ? 4'b0100 : 4'b0000;
            checks++;
            if (req_ready !== x) begin errors++; $display("FAIL fair_ready t=%0d got=%b exp=%b", t, req_ready, x); end
            tick();
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_tie();
        logic [3:0] first, second;
`ifdef FP_ARB_FIXED_PRIO_EN
        first = 4'b0001;
        second = 4'b0100;
`else
        first = 4'b0100;
        second = 4'b0001;
`endif
        do_reset();
        set_ops(0, 32'h40C00000, 32'h40E00000);
        set_ops(1, 32'h40800000, 32'hBF800000);
        set_ops(2, 32'h40E80000, 32'h3EC00000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_drain();
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== first) begin errors++; $display("FAIL tie_first got=%b exp=%b", req_ready, first); end
        tick();
        checks++;
        if (req_ready !== second) begin errors++; $display("FAIL tie_second got=%b exp=%b", req_ready, second); end
        tick();
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int c, n;
        do_reset();
        set_ops(0, 32'h40800000, 32'hBF800000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b0001;
        #1;
        checks++;
        if ({res_valid, req_ready} !== 5'b00001) begin errors++; $display("FAIL rstmid_regrant got=%b exp=00001", {res_valid, req_ready}); end
        c = cyc;
        tick();
        req_valid = '0;
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        checks++;
        if (cyc - c !== 1 + LAT) begin errors++; $display("FAIL rstmid_first_result got=%0d exp=%0d", cyc - c, 1 + LAT); end
        wait_drain();
    endtask

    task automatic test_collision();
        do_reset();
        set_ops(0, 32'h40800000, 32'hBF800000);
        set_ops(1, 32'h40C00000, 32'h40E00000);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int k = 0; k < LAT; k++) tick();
        req_valid = 4'b0010;
        #1;
        checks++;
        if ({res_valid, res_id, req_ready} !== 7'b1000010) begin
            errors++; $display("FAIL collide_both got=%b exp=1000010", {res_valid, res_id, req_ready});
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL collide_pend1 got=%b exp=0000", req_ready); end
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL collide_clr0 got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_back_to_back();
        test_fairness();
        test_tie();
        test_reset_mid();
        test_collision();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end
endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one pipelined floating-point adder (fp_add_2) between N requesters, e.g. the CNN partial-sum lanes.
- Each requester issues operand pairs over a valid/ready handshake. The block grants one requester per cycle by round-robin and drives the adder operands.
- It tracks in-flight operations with an ID shift register, reassembles the adder's split sign/exponent/mantissa outputs into one 32-bit word, and returns each result tagged with the requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester ID; must satisfy 2^ID_W >= N_REQ.
- ADD_LATENCY, 1, adder latency: clock edges from operands valid at A_FP/B_FP to result valid at sign/exponent/mantissa (1..8).
- EXPONENT_WIDTH, 8, adder exponent width.
- MANTISSA_WIDTH, 23, adder mantissa width; word width W = 1+EXPONENT_WIDTH+MANTISSA_WIDTH (32).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand pair valid.
- req_ready  out  N_REQ  per-requester grant; at most one bit high per cycle.
- req_a  in  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  in  N_REQ*W  packed operand B, same packing as req_a.
- add_a  out  W  registered operand to adder A_FP.
- add_b  out  W  registered operand to adder B_FP.
- add_sign  in  1  adder sign output.
- add_exp  in  EXPONENT_WIDTH  adder exponent output.
- add_mant  in  MANTISSA_WIDTH  adder mantissa output.
- res_valid  out  1  result valid; single-cycle pulse per operation.
- res_id  out  ID_W  requester ID of the result.
- res_data  out  W  result word = {add_sign, add_exp, add_mant}.
- idle  out  1  high when no operation is in flight and no grant is active this cycle.

Behaviour:
- Reset values: add_a=0, add_b=0, res_valid=0, res_id=0, pending=0, rr_ptr=0, tag pipe cleared.
  - Reset asserted mid-operation flushes all in-flight tags; adder results still emerging after reset are discarded (res_valid stays 0).
- Eligibility: eligible[i] = req_valid[i] & ~pending[i].
  - Each requester may have at most one operation outstanding.
- Grant selection:
  - Combinational round-robin: first eligible index starting at rr_ptr, wrapping N_REQ-1 -> 0.
  - req_ready[g] = 1 for the selected index only; all zeros if none eligible.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: transfer in cycle c when req_valid[g] & req_ready[g]. At the closing edge of cycle c:
  - add_a <= req_a[g], add_b <= req_b[g];
  - pending[g] <= 1;
  - rr_ptr <= (g+1) mod N_REQ;
  - tag pipe stage 0 <= {1, g}.
- No grant in a cycle: add_a/add_b hold their value; tag stage 0 <= {0, x}; rr_ptr holds.
- Tag pipe has ADD_LATENCY+1 stages and shifts every cycle.
  - Its tail drives res_valid and res_id, so res_valid is asserted in cycle c+1+ADD_LATENCY.
  - res_data is combinational from the adder outputs.
- Results are not backpressured; consumers must accept res_valid when it is asserted.
- Pending clear: pending[res_id] clears at the edge ending the res_valid cycle.
  - The earliest re-grant of the same requester is cycle c+2+ADD_LATENCY.
- Simultaneous events: a result for requester j and a grant to requester k != j in the same cycle are both honoured. A grant to j in its own result cycle is impossible because pending[j] is still 1.
- Throughput: one issue per cycle whenever distinct eligible requesters exist. Results return in issue order.
- Round-robin pointer behaviour:
  - The pointer advances only on a grant.
  - A requester dropping valid before it is granted loses nothing and is not penalised.
- idle = (tag pipe all invalid) & (req_ready == 0).

Optional Feature:
- Macro FP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest eligible index wins and rr_ptr is removed (rr_ptr and fairness no longer apply).
- Undefined: round-robin as specified above.

Test Plan:
- Single op, requester 0: A=0x40800000 (4), B=0xBF800000 (-1), ADD_LATENCY=1 -> res_valid in cycle c+2, res_id=0, res_data=0x40400000 (3); idle=1 afterwards.
- All 4 requesters valid in the same cycle: r0 6+7 (0x40C00000,0x40E00000), r1 7.25+0.375 (0x40E80000,0x3EC00000), r2 -0.5+0.5 (0xBF000000,0x3F000000), r3 4+(-1).
  - Grants 0,1,2,3 on consecutive cycles.
  - Results in order: 0x41500000, 0x40F40000, 0x00000000, 0x40400000, with IDs 0..3.
- Requester 1 held valid continuously, ADD_LATENCY=3: req_ready[1] is high once, then low until the cycle after its res_valid; the next grant occurs exactly 5 cycles after the first.
- Fairness: r0 and r2 both held valid, rr_ptr=0 -> grants alternate 0,2,0,2 (each re-grant gated by its pending bit); neither requester is starved.
  - With FP_ARB_FIXED_PRIO_EN defined, r0 wins every tie.
- Reset asserted one cycle after a grant -> res_valid never pulses for that op; pending=0; req_ready available in the first cycle after reset deasserts.
- Result/grant collision: r0 result cycle coincides with a grant to r1 -> both occur; pending[0] clears and pending[1] sets on the same edge.
